// File: rtl/dc_pred_sched.sv
// DC predictor and encoder handshake scheduler: forms per-component DC differences,
// launches the DC Huffman encoder, and returns its code to the downstream stage.
//
// state | meaning
// IDLE  | ready for the next block; illegal component pulses err_o
// ISSUE | one-cycle start strobe to the encoder with the registered difference
// WAIT  | waiting for encoder completion, bounded by DONE_TIMEOUT cycles
// OUT   | holding the captured code until downstream accepts it
module dc_pred_sched #(
    parameter int DC_IN_WIDTH  = 16,
    parameter int DC_OUT_WIDTH = 23,
    parameter int DONE_TIMEOUT = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    blk_valid_i,
    output logic                    blk_ready_o,
    input  logic [DC_IN_WIDTH-1:0]  blk_dc_i,
    input  logic [1:0]              blk_comp_i,
    input  logic                    blk_sof_i,
    output logic                    dc_go_o,
    output logic                    dc_frame_o,
    output logic [DC_IN_WIDTH-1:0]  dc_diff_o,
    input  logic                    dc_done_i,
    input  logic [4:0]              dc_len_i,
    input  logic [DC_OUT_WIDTH-1:0] dc_seq_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [4:0]              out_len_o,
    output logic [DC_OUT_WIDTH-1:0] out_seq_o,
    output logic [1:0]              out_comp_o,
    output logic                    err_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(DONE_TIMEOUT - 1);
    localparam logic [DC_IN_WIDTH-1:0] SAT_MAX = {1'b0, {(DC_IN_WIDTH-1){1'b1}}};
    localparam logic [DC_IN_WIDTH-1:0] SAT_MIN = {1'b1, {(DC_IN_WIDTH-1){1'b0}}};

    state_t                  state, state_nxt;
    logic [DC_IN_WIDTH-1:0]  pred_y, pred_cb, pred_cr;
    logic [DC_IN_WIDTH-1:0]  pred_cur;
    logic [DC_IN_WIDTH:0]    diff_wide;
    logic [DC_IN_WIDTH-1:0]  diff_sat;
    logic [7:0]              wait_cnt;
    logic                    sof_r;
    logic                    accept, legal, timeout;

    assign blk_ready_o = (state == IDLE);
    assign accept      = blk_valid_i && blk_ready_o;
    assign legal       = (blk_comp_i != 2'd3);
    assign timeout     = (state == WAIT) && !dc_done_i && (wait_cnt == 8'd0);
    assign dc_go_o     = (state == ISSUE);
    assign dc_frame_o  = (state == ISSUE) && sof_r;
    assign out_valid_o = (state == OUT);

    // Start of picture zeroes the reference, so the difference equals the raw DC.
    always_comb begin
        case (blk_comp_i)
            2'd1:    pred_cur = pred_cb;
            2'd2:    pred_cur = pred_cr;
            default: pred_cur = pred_y;
        endcase
        if (blk_sof_i) pred_cur = '0;
        diff_wide = {blk_dc_i[DC_IN_WIDTH-1], blk_dc_i} - {pred_cur[DC_IN_WIDTH-1], pred_cur};
        if (diff_wide[DC_IN_WIDTH] != diff_wide[DC_IN_WIDTH-1])
            diff_sat = diff_wide[DC_IN_WIDTH] ? SAT_MIN : SAT_MAX;
        else
            diff_sat = diff_wide[DC_IN_WIDTH-1:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && legal) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (dc_done_i) state_nxt = OUT;
                     else if (timeout) state_nxt = IDLE;
            OUT:     if (out_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            pred_y     <= '0;
            pred_cb    <= '0;
            pred_cr    <= '0;
            wait_cnt   <= '0;
            sof_r      <= 1'b0;
            dc_diff_o  <= '0;
            out_len_o  <= '0;
            out_seq_o  <= '0;
            out_comp_o <= '0;
            err_o      <= 1'b0;
        end else begin
            state <= state_nxt;
            err_o <= (accept && !legal) || timeout;
            if (accept && legal) begin
                if (blk_sof_i) begin
                    pred_y  <= '0;
                    pred_cb <= '0;
                    pred_cr <= '0;
                end
                case (blk_comp_i)
                    2'd1:    pred_cb <= blk_dc_i;
                    2'd2:    pred_cr <= blk_dc_i;
                    default: pred_y  <= blk_dc_i;
                endcase
                dc_diff_o  <= diff_sat;
                sof_r      <= blk_sof_i;
                out_comp_o <= blk_comp_i;
            end
            // Down-counter loaded on entry to WAIT; reaching zero is the timeout point.
            if (state == ISSUE)
                wait_cnt <= WAIT_LAST;
            else if (state == WAIT && wait_cnt != 8'd0)
                wait_cnt <= wait_cnt - 8'd1;
            if (state == WAIT && dc_done_i) begin
                out_len_o <= dc_len_i;
                out_seq_o <= dc_seq_i;
            end
        end
    end

endmodule

// File: tb/tb_dc_pred_sched.sv
// Self-checking bench for dc_pred_sched: directed scenarios plus random blocks
// compared against an arithmetic predictor model.
module tb_dc_pred_sched;

    localparam int T = 64;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        blk_valid_i;
    logic        blk_ready_o;
    logic [15:0] blk_dc_i;
    logic [1:0]  blk_comp_i;
    logic        blk_sof_i;
    logic        dc_go_o;
    logic        dc_frame_o;
    logic [15:0] dc_diff_o;
    logic        dc_done_i;
    logic [4:0]  dc_len_i;
    logic [22:0] dc_seq_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [4:0]  out_len_o;
    logic [22:0] out_seq_o;
    logic [1:0]  out_comp_o;
    logic        err_o;

    int errors = 0;
    int checks = 0;
    int pred [3];

    dc_pred_sched #(.DC_IN_WIDTH(16), .DC_OUT_WIDTH(23), .DONE_TIMEOUT(T)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o),
        .blk_dc_i(blk_dc_i), .blk_comp_i(blk_comp_i), .blk_sof_i(blk_sof_i),
        .dc_go_o(dc_go_o), .dc_frame_o(dc_frame_o), .dc_diff_o(dc_diff_o),
        .dc_done_i(dc_done_i), .dc_len_i(dc_len_i), .dc_seq_i(dc_seq_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_len_o(out_len_o), .out_seq_o(out_seq_o), .out_comp_o(out_comp_o),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // done_lat: done driven in WAIT cycle done_lat-1 (1 = immediate); 0 = never (timeout).
    task automatic do_block(input int dc, input int comp, input bit sof,
                            input int done_lat, input int rdy_lat, input int exp_diff_in);
        int exp_diff;
        int len, seq;
        int err_cnt, err_k, ov_cnt;
        chk("ready_before", int'(blk_ready_o), 1);
        blk_valid_i = 1'b1;
        blk_dc_i    = 16'(dc);
        blk_comp_i  = 2'(comp);
        blk_sof_i   = sof;
        tick();
        blk_valid_i = 1'b0;
        blk_sof_i   = 1'b0;
        if (comp == 3) begin
            chk("illegal_err", int'(err_o), 1);
            chk("illegal_go", int'(dc_go_o), 0);
            chk("illegal_ready", int'(blk_ready_o), 1);
            tick();
            chk("illegal_err_end", int'(err_o), 0);
            return;
        end
        if (sof) pred = '{0, 0, 0};
        exp_diff = sat16(dc - pred[comp]);
        pred[comp] = dc;
        if (exp_diff_in != 99999) chk("directed_diff", exp_diff, exp_diff_in);
        chk("go", int'(dc_go_o), 1);
        chk("frame", int'(dc_frame_o), int'(sof));
        chk("diff", int'($signed(dc_diff_o)), exp_diff);
        tick();
        chk("go_single", int'(dc_go_o), 0);
        if (done_lat == 0) begin
            err_cnt = 0; err_k = -1; ov_cnt = 0;
            for (int k = 0; k <= T + 2; k++) begin
                if (err_o) begin err_cnt++; err_k = k; end
                if (out_valid_o) ov_cnt++;
                if (k < T + 2) tick();
            end
            chk("timeout_err_count", err_cnt, 1);
            chk("timeout_err_cycle", err_k, T);
            chk("timeout_no_out", ov_cnt, 0);
            chk("timeout_idle", int'(blk_ready_o), 1);
            return;
        end
        for (int k = 0; k < done_lat - 1; k++) tick();
        len = int'($urandom_range(0, 31));
        seq = int'($urandom_range(0, 32'h7F_FFFF));
        dc_done_i = 1'b1;
        dc_len_i  = 5'(len);
        dc_seq_i  = 23'(seq);
        tick();
        dc_done_i = 1'b0;
        dc_len_i  = 5'($urandom);
        dc_seq_i  = 23'($urandom);
        chk("no_err", int'(err_o), 0);
        for (int k = 0; k <= rdy_lat; k++) begin
            chk("out_valid", int'(out_valid_o), 1);
            chk("out_len", int'(out_len_o), len);
            chk("out_seq", int'(out_seq_o), seq);
            chk("out_comp", int'(out_comp_o), comp);
            chk("diff_hold", int'($signed(dc_diff_o)), exp_diff);
            chk("busy", int'(blk_ready_o), 0);
            if (k == rdy_lat) out_ready_i = 1'b1;
            tick();
        end
        out_ready_i = 1'b0;
        chk("out_done", int'(out_valid_o), 0);
        chk("ready_after", int'(blk_ready_o), 1);
    endtask

    initial begin
        rst_i = 1'b1; blk_valid_i = 1'b0; blk_dc_i = '0; blk_comp_i = '0; blk_sof_i = 1'b0;
        dc_done_i = 1'b0; dc_len_i = '0; dc_seq_i = '0; out_ready_i = 1'b0;
        pred = '{0, 0, 0};
        tick(); tick();
        rst_i = 1'b0;
        chk("rst_ready", int'(blk_ready_o), 1);
        chk("rst_go", int'(dc_go_o), 0);
        chk("rst_frame", int'(dc_frame_o), 0);
        chk("rst_valid", int'(out_valid_o), 0);
        chk("rst_err", int'(err_o), 0);
        chk("rst_diff", int'(dc_diff_o), 0);
        chk("rst_len", int'(out_len_o), 0);
        chk("rst_seq", int'(out_seq_o), 0);
        chk("rst_comp", int'(out_comp_o), 0);

        // Stray done while idle must be ignored.
        dc_done_i = 1'b1; tick(); dc_done_i = 1'b0;
        chk("stray_done", int'(out_valid_o), 0);

        do_block(22, 0, 1, 1, 0, 22);
        do_block(29, 0, 0, 1, 0, 7);
        do_block(37, 0, 0, 1, 0, 8);

        do_block(100, 0, 1, 1, 0, 100);
        do_block(-5, 1, 0, 2, 1, -5);
        do_block(10, 2, 0, 1, 0, 10);
        do_block(90, 0, 0, 3, 0, -10);
        do_block(-5, 1, 0, 1, 2, 0);

        do_block(-32768, 1, 0, 1, 0, 99999);
        do_block(32767, 1, 0, 1, 0, 32767);
        do_block(-32768, 1, 0, 1, 0, -32768);

        do_block(123, 2, 0, 0, 0, 99999);
        do_block(200, 2, 0, 1, 0, 77);
        do_block(-1, 0, 0, T, 0, 99999);

        do_block(7, 0, 0, 1, 10, 99999);

        // Reset while waiting for the encoder discards the block.
        blk_valid_i = 1'b1; blk_dc_i = 16'd1; blk_comp_i = 2'd0; blk_sof_i = 1'b0;
        tick();
        blk_valid_i = 1'b0;
        tick();
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        pred = '{0, 0, 0};
        dc_done_i = 1'b1; tick(); dc_done_i = 1'b0;
        chk("rst_wait_no_out", int'(out_valid_o), 0);
        chk("rst_wait_idle", int'(blk_ready_o), 1);
        do_block(50, 0, 0, 1, 0, 50);
        do_block(9, 3, 0, 1, 0, 99999);
        do_block(60, 0, 0, 1, 0, 10);

        for (int i = 0; i < 40; i++) begin
            int c;
            c = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            do_block($signed(16'($urandom)), c, $urandom_range(0, 7) == 0,
                     int'($urandom_range(1, 5)), int'($urandom_range(0, 3)), 99999);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dc_pred_sched.md
DC_PRED_SCHED -- requirements
Module: dc_pred_sched

Parameters
REQ-001 DC_IN_WIDTH, default 16, width of the raw quantized DC value and of the difference sent to the encoder (signed two's complement).
REQ-002 DC_OUT_WIDTH, default 23, width of the Huffman code sequence returned by the encoder.
REQ-003 DONE_TIMEOUT, default 64, maximum cycles to wait for dc_done_i before aborting; range 2..255.

Interface
REQ-004 clk_i  input  1  single clock; all logic on rising edge.
REQ-005 rst_i  input  1  synchronous, active-high reset.
REQ-006 blk_valid_i  input  1  upstream block DC available.
REQ-007 blk_ready_o  output  1  block accepted when blk_valid_i & blk_ready_o.
REQ-008 blk_dc_i  input  DC_IN_WIDTH  raw quantized DC coefficient, signed.
REQ-009 blk_comp_i  input  2  component: 0=Y, 1=Cb, 2=Cr, 3=illegal.
REQ-010 blk_sof_i  input  1  first block of a new picture, qualified by acceptance.
REQ-011 dc_go_o  output  1  one-cycle start strobe to the DC Huffman encoder.
REQ-012 dc_frame_o  output  1  new-picture flag to the encoder, asserted together with dc_go_o.
REQ-013 dc_diff_o  output  DC_IN_WIDTH  predicted DC difference to the encoder.
REQ-014 dc_done_i  input  1  encoder completion strobe.
REQ-015 dc_len_i  input  5  encoder code length, valid with dc_done_i.
REQ-016 dc_seq_i  input  DC_OUT_WIDTH  encoder code bits, valid with dc_done_i.
REQ-017 out_valid_o  output  1  encoded result available downstream.
REQ-018 out_ready_i  input  1  downstream accepts result when out_valid_o & out_ready_i.
REQ-019 out_len_o  output  5  captured code length.
REQ-020 out_seq_o  output  DC_OUT_WIDTH  captured code bits.
REQ-021 out_comp_o  output  2  component of the captured result.
REQ-022 err_o  output  1  one-cycle pulse on illegal component or encoder timeout.

Function
REQ-023 FSM states: IDLE, ISSUE, WAIT, OUT; blk_ready_o is 1 only in IDLE.
REQ-024 IDLE: on acceptance with blk_comp_i 0..2, compute diff, update predictor, and go to ISSUE.
REQ-025 Three signed predictors, one per component: pred[c] <= blk_dc_i on acceptance of component c.
REQ-026 If blk_sof_i is set at acceptance, clear all three predictors before computing diff, so diff = blk_dc_i.
REQ-027 diff = blk_dc_i - pred[c], computed at DC_IN_WIDTH+1 bits and saturated to the signed DC_IN_WIDTH range (16 bits: -32768..32767).
REQ-028 dc_diff_o is registered at acceptance and held stable until the FSM returns to IDLE.
REQ-029 ISSUE lasts exactly one cycle, with dc_go_o=1 and dc_frame_o equal to the registered blk_sof_i; the FSM then goes to WAIT.
REQ-030 dc_go_o rises one cycle after acceptance.
REQ-031 dc_done_i is sampled only in WAIT and ignored in all other states.
REQ-032 WAIT with dc_done_i=1: capture dc_len_i/dc_seq_i into out_len_o/out_seq_o and go to OUT.
REQ-033 WAIT cycle counter starts at 0 on entry; at count DONE_TIMEOUT-1 without dc_done_i, pulse err_o, return to IDLE, and produce no output.
REQ-034 If dc_done_i arrives in the same cycle as the timeout limit, done wins and there is no error.
REQ-035 OUT: out_valid_o=1 with out_len_o/out_seq_o/out_comp_o held stable until out_ready_i, then return to IDLE next cycle.
REQ-036 Illegal component (3) accepted in IDLE: pulse err_o next cycle, leave predictors unchanged, issue no dc_go_o, and stay in IDLE.
REQ-037 Minimum block period is 4 cycles (accept, ISSUE, WAIT with immediate done, OUT with ready high).

Reset
REQ-038 While rst_i is high at a clock edge: state=IDLE, all predictors=0, counter=0.
REQ-039 Reset values: blk_ready_o=1 after release, and dc_go_o, dc_frame_o, out_valid_o, err_o=0.
REQ-040 Reset values: dc_diff_o, out_len_o, out_seq_o, out_comp_o=0.
REQ-041 Reset asserted mid-operation (ISSUE/WAIT/OUT) aborts the block and discards it; a dc_done_i arriving after reset is ignored.

Verification
REQ-042 Y blocks 22 (sof=1), then 29, 37, encoder done 1 cycle after go -> dc_diff_o 22, 7, 8; dc_frame_o=1 only on the first.
REQ-043 Interleaved Y=100, Cb=-5, Cr=10, Y=90, Cb=-5 -> diffs 100, -5, 10, -10, 0.
REQ-044 Cb predictor -32768, then Cb=32767 -> diff saturates to 32767; reverse case -> -32768.
REQ-045 No dc_done_i for 64 cycles -> err_o pulses once, FSM returns to IDLE, out_valid_o never asserts; the next block proceeds normally.
REQ-046 out_ready_i held low for 10 cycles -> out_valid_o and data stable throughout, blk_ready_o=0, and the next block is accepted the cycle after the OUT state exits.
REQ-047 rst_i pulsed in WAIT, then Y=50 without sof -> dc_diff_o=50 (predictor cleared); blk_comp_i=3 -> err_o pulse and no dc_go_o.
